// File: rtl/reglk_pkg.sv
// Shared definitions for the register-lock bank: FSM state encoding,
// the COMMIT magic value and the control-word offsets above the data registers.
package reglk_pkg;

  typedef enum logic [1:0] {
    ST_OPEN      = 2'd0,
    ST_COMMITTED = 2'd1,
    ST_WIPE      = 2'd2
  } reglk_state_e;

  // Value that must be written to the COMMIT word to lock the bank
  localparam logic [7:0] COMMIT_MAGIC = 8'hA5;

  // Control word addresses, relative to NUM_REGS
  localparam int WLOCK_OFS      = 0;
  localparam int RLOCK_OFS      = 1;
  localparam int COMMIT_OFS     = 2;
  localparam int NUM_CTRL_WORDS = 3;

endpackage

// File: rtl/reglk_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module reglk_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count increments, holding at all-ones
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= sat_inc(cnt_o);
    end
  end

endmodule

// File: rtl/reglk_bank.sv
// Lockable register bank. NUM_REGS data registers with sticky write/read
// lock masks, a one-way COMMIT lock, and a debug-triggered wipe that clears
// one register per cycle. Requests are granted combinationally and answered
// exactly one cycle later.
// Optional feature: define REGLK_VIOL_CNT_EN to build the saturating
// violation counter; otherwise viol_cnt_o is tied to zero.
module reglk_bank
  import reglk_pkg::*;
#(
  parameter int  NUM_REGS = 6,
  parameter int  REG_W    = 32,
  parameter int  CNT_W    = 8,
  localparam int AW       = $clog2(NUM_REGS + NUM_CTRL_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      jtag_unlock_i,
  input  logic                      acct_ctrl_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             addr_i,
  input  logic [REG_W-1:0]          wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [REG_W-1:0]          rdata_o,
  output logic                      err_o,
  output logic [NUM_REGS*REG_W-1:0] reglk_ctrl_o,
  output logic                      locked_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          viol_cnt_o
);

  // Number of mask bits that map onto data-word bits
  localparam int MW = (NUM_REGS < REG_W) ? NUM_REGS : REG_W;

  // Mask bits come from the low bits of a write word; higher bits are ignored
  function automatic logic [NUM_REGS-1:0] word_to_mask(input logic [REG_W-1:0] w);
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int i = 0; i < MW; i++) m[i] = w[i];
    return m;
  endfunction

  // Masks read back zero-extended into a data word
  function automatic logic [REG_W-1:0] mask_to_word(input logic [NUM_REGS-1:0] m);
    logic [REG_W-1:0] w;
    w = '0;
    for (int i = 0; i < MW; i++) w[i] = m[i];
    return w;
  endfunction

  reglk_state_e        state;
  logic [REG_W-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] wlock;
  logic [NUM_REGS-1:0] rlock;
  logic                jtag_q;
  logic [AW-1:0]       wipe_idx;

  logic                wipe_start;
  logic                wipe_last;
  logic                gnt;
  logic [NUM_REGS-1:0] sel;
  logic                hit_data;
  logic                hit_wlock;
  logic                hit_rlock;
  logic                hit_commit;
  logic [REG_W-1:0]    sel_data;
  logic [REG_W-1:0]    status_word;

  logic                resp_err;
  logic [REG_W-1:0]    resp_rdata;
  logic                wr_data;
  logic                wr_wlock;
  logic                wr_rlock;
  logic                go_commit;

  assign gnt        = req_i && (state != ST_WIPE);
  assign gnt_o      = gnt;
  assign locked_o   = (state == ST_COMMITTED);
  assign busy_o     = (state == ST_WIPE);
  assign wipe_start = jtag_unlock_i && !jtag_q && (state != ST_WIPE);
  assign wipe_last  = (wipe_idx == AW'(NUM_REGS - 1));

  assign hit_data   = |sel;
  assign hit_wlock  = (addr_i == AW'(NUM_REGS + WLOCK_OFS));
  assign hit_rlock  = (addr_i == AW'(NUM_REGS + RLOCK_OFS));
  assign hit_commit = (addr_i == AW'(NUM_REGS + COMMIT_OFS));

  // Previous unlock level, for rising-edge detection; tracked through reset
  // so an unlock held high across reset does not start a spurious wipe
  always_ff @(posedge clk_i) begin
    jtag_q <= jtag_unlock_i;
  end

  // One-hot data register select and read mux
  always_comb begin
    sel      = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (addr_i == AW'(i));
      if (sel[i]) sel_data = regs[i];
    end
  end

  // COMMIT word read value: {busy, locked} in the low bits
  always_comb begin
    status_word    = '0;
    status_word[0] = locked_o;
    status_word[1] = busy_o;
  end

  // Access decode: permission, lock checks and the response to return
  always_comb begin
    resp_err   = 1'b0;
    resp_rdata = '0;
    wr_data    = 1'b0;
    wr_wlock   = 1'b0;
    wr_rlock   = 1'b0;
    go_commit  = 1'b0;
    if (!acct_ctrl_i || !(hit_data || hit_wlock || hit_rlock || hit_commit)) begin
      resp_err = 1'b1;
    end else if (we_i) begin
      if (wipe_start) begin
        // A wipe starting this cycle discards the write
        resp_err = 1'b1;
      end else if (hit_data) begin
        if ((|(sel & wlock)) || (state == ST_COMMITTED)) resp_err = 1'b1;
        else                                             wr_data  = 1'b1;
      end else if (hit_wlock || hit_rlock) begin
        if (state == ST_COMMITTED) begin
          resp_err = 1'b1;
        end else begin
          wr_wlock = hit_wlock;
          wr_rlock = hit_rlock;
        end
      end else begin
        if ((state == ST_OPEN) && (wdata_i == REG_W'(COMMIT_MAGIC))) go_commit = 1'b1;
        else                                                        resp_err  = 1'b1;
      end
    end else begin
      if (hit_data) begin
        if (|(sel & rlock)) resp_err   = 1'b1;
        else                resp_rdata = sel_data;
      end else if (hit_wlock) begin
        resp_rdata = mask_to_word(wlock);
      end else if (hit_rlock) begin
        resp_rdata = mask_to_word(rlock);
      end else begin
        resp_rdata = status_word;
      end
    end
  end

  // FSM: OPEN/COMMITTED enter WIPE on an unlock edge; WIPE walks the registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_OPEN;
      wipe_idx <= '0;
    end else begin
      case (state)
        ST_OPEN, ST_COMMITTED: begin
          if (wipe_start) begin
            state    <= ST_WIPE;
            wipe_idx <= '0;
          end else if (gnt && go_commit) begin
            state <= ST_COMMITTED;
          end
        end
        ST_WIPE: begin
          if (wipe_last) state    <= ST_OPEN;
          else           wipe_idx <= wipe_idx + AW'(1);
        end
        default: state <= ST_OPEN;
      endcase
    end
  end

  // Data registers: granted writes, or one register cleared per wipe cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((state == ST_WIPE) && (wipe_idx == AW'(i))) regs[i] <= '0;
        else if (gnt && wr_data && sel[i])              regs[i] <= wdata_i;
      end
    end
  end

  // Sticky lock masks: bits only set by writes, cleared at the end of a wipe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wlock <= '0;
      rlock <= '0;
    end else if ((state == ST_WIPE) && wipe_last) begin
      wlock <= '0;
      rlock <= '0;
    end else begin
      if (gnt && wr_wlock) wlock <= wlock | word_to_mask(wdata_i);
      if (gnt && wr_rlock) rlock <= rlock | word_to_mask(wdata_i);
    end
  end

  // Response stage: one cycle after each grant; data and error zero otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= gnt;
      rdata_o  <= gnt ? resp_rdata : '0;
      err_o    <= gnt && resp_err;
    end
  end

  // Flattened register view, register 0 in the LSBs
  always_comb begin
    reglk_ctrl_o = '0;
    for (int i = 0; i < NUM_REGS; i++) reglk_ctrl_o[i*REG_W +: REG_W] = regs[i];
  end

`ifdef REGLK_VIOL_CNT_EN
  reglk_sat_counter #(
    .CNT_W(CNT_W)
  ) u_viol_cnt (
    .clk_i(clk_i),
    .clr_i(rst_i),
    .inc_i(gnt && resp_err),
    .cnt_o(viol_cnt_o)
  );
`else
  assign viol_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reglk_bank.sv
// Self-checking bench for reglk_bank: directed vector table, wipe and reset
// sequences, and randomized accesses against a behavioural model.
module tb_reglk_bank;

  localparam int NR = 6;
  localparam int RW = 32;
  localparam int CW = 8;
  localparam int AW = $clog2(NR + 3);
`ifdef REGLK_VIOL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, jtag, acct, req, we;
  logic [AW-1:0]  addr;
  logic [RW-1:0]  wdata;
  logic           gnt, rvalid, err, locked, busy;
  logic [RW-1:0]  rdata;
  logic [NR*RW-1:0] ctrl;
  logic [CW-1:0]  viol;

  always #5 clk = ~clk;

  reglk_bank #(.NUM_REGS(NR), .REG_W(RW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .jtag_unlock_i(jtag), .acct_ctrl_i(acct),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .reglk_ctrl_o(ctrl), .locked_o(locked), .busy_o(busy), .viol_cnt_o(viol)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [RW-1:0] m_regs [NR];
  bit [NR-1:0]   m_wl, m_rl;
  bit            m_locked;
  int            m_viol;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_wl = '0; m_rl = '0; m_locked = 1'b0; m_viol = 0;
  endfunction

  function automatic void m_wipe();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_wl = '0; m_rl = '0; m_locked = 1'b0;
  endfunction

  function automatic int exp_viol();
    return CNT_EN ? m_viol : 0;
  endfunction

  function automatic void m_access(input bit w, input int a, input logic [RW-1:0] d,
                                   input bit ac, output logic [RW-1:0] rd, output bit e);
    rd = '0; e = 1'b0;
    if (!ac || a > NR + 2) e = 1'b1;
    else if (a < NR) begin
      if (w) begin
        if (m_wl[a] || m_locked) e = 1'b1; else m_regs[a] = d;
      end else begin
        if (m_rl[a]) e = 1'b1; else rd = m_regs[a];
      end
    end else if (a == NR) begin
      if (w) begin if (m_locked) e = 1'b1; else m_wl |= d[NR-1:0]; end
      else rd = RW'(m_wl);
    end else if (a == NR + 1) begin
      if (w) begin if (m_locked) e = 1'b1; else m_rl |= d[NR-1:0]; end
      else rd = RW'(m_rl);
    end else begin
      if (w) begin
        if (!m_locked && d == 32'hA5) m_locked = 1'b1; else e = 1'b1;
      end else rd = RW'(m_locked);
    end
    if (e && m_viol < (1 << CW) - 1) m_viol++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; we = 1'b0; jtag = 1'b0; acct = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic xact(input bit w, input int a, input logic [RW-1:0] d, input bit ac,
                      output logic [RW-1:0] rd, output bit e, output bit g);
    @(negedge clk);
    req = 1'b1; we = w; addr = AW'(a); wdata = d; acct = ac;
    #1 g = gnt;
    @(negedge clk);
    req = 1'b0; we = 1'b0; acct = 1'b1;
    chk("rvalid_after_gnt", 64'(rvalid), 64'(1));
    rd = rdata; e = err;
  endtask

  typedef struct {
    bit            we;
    int            addr;
    logic [RW-1:0] wd;
    bit            acct;
    bit            exp_err;
    logic [RW-1:0] exp_rd;
    bit            exp_locked;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [RW-1:0] rd, mrd;
    bit e, g, me;
    int n, nerr;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] rd, mrd;
    bit e, g, me;
    int n, nerr, a;
    bit w;
    logic [RW-1:0] d;

    tbl[0]  = '{1, 2, 32'h1234_5678, 1, 0, 32'h0,         0};
    tbl[1]  = '{0, 2, 32'h0,         1, 0, 32'h1234_5678, 0};
    tbl[2]  = '{1, 6, 32'h4,         1, 0, 32'h0,         0};
    tbl[3]  = '{1, 2, 32'hFFFF_FFFF, 1, 1, 32'h0,         0};
    tbl[4]  = '{0, 2, 32'h0,         1, 0, 32'h1234_5678, 0};
    tbl[5]  = '{0, 6, 32'h0,         1, 0, 32'h4,         0};
    tbl[6]  = '{1, 7, 32'h1,         1, 0, 32'h0,         0};
    tbl[7]  = '{0, 0, 32'h0,         1, 1, 32'h0,         0};
    tbl[8]  = '{1, 7, 32'h0,         1, 0, 32'h0,         0};
    tbl[9]  = '{0, 7, 32'h0,         1, 0, 32'h1,         0};
    tbl[10] = '{1, 1, 32'hCAFE,      0, 1, 32'h0,         0};
    tbl[11] = '{0, 1, 32'h0,         0, 1, 32'h0,         0};
    tbl[12] = '{0, 1, 32'h0,         1, 0, 32'h0,         0};
    tbl[13] = '{1, 9, 32'h1,         1, 1, 32'h0,         0};
    tbl[14] = '{0, 15, 32'h0,        1, 1, 32'h0,         0};
    tbl[15] = '{1, 8, 32'h5A,        1, 1, 32'h0,         0};
    tbl[16] = '{0, 8, 32'h0,         1, 0, 32'h0,         0};
    tbl[17] = '{1, 8, 32'hA5,        1, 0, 32'h0,         1};
    tbl[18] = '{0, 8, 32'h0,         1, 0, 32'h1,         1};
    tbl[19] = '{1, 3, 32'h1,         1, 1, 32'h0,         1};
    tbl[20] = '{1, 6, 32'h2,         1, 1, 32'h0,         1};
    tbl[21] = '{0, 2, 32'h0,         1, 0, 32'h1234_5678, 1};

    rst = 1'b1; jtag = 1'b0; acct = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_err",    64'(err),    64'(0));
    chk("rst_rdata",  64'(rdata),  64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_viol",   64'(viol),   64'(0));
    chk("rst_gnt_idle", 64'(gnt),  64'(0));
    for (int i = 0; i < NR; i++) chk("rst_reg", 64'(ctrl[i*RW +: RW]), 64'(0));
    rst = 1'b0;
    m_reset();

    // Directed vector table
    nerr = 0;
    for (int i = 0; i < 22; i++) begin
      xact(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].acct, rd, e, g);
      if (tbl[i].exp_err) nerr++;
      chk($sformatf("tbl%0d_gnt", i),    64'(g),      64'(1));
      chk($sformatf("tbl%0d_err", i),    64'(e),      64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i),  64'(rd),     64'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].exp_locked));
      chk($sformatf("tbl%0d_viol", i),   64'(viol),   64'(CNT_EN ? nerr : 0));
    end
    chk("tbl_reg2", 64'(ctrl[2*RW +: RW]), 64'(32'h1234_5678));
    chk("tbl_reg1", 64'(ctrl[1*RW +: RW]), 64'(0));

    // Wipe from COMMITTED: stall requests, exactly NR busy cycles, ignore edges
    @(negedge clk);
    jtag = 1'b1;
    @(negedge clk);
    chk("wipe_busy_first", 64'(busy), 64'(1));
    req = 1'b1; we = 1'b0; addr = AW'(0);
    #1 chk("wipe_stall_gnt", 64'(gnt), 64'(0));
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("wipe_stall_gnt", 64'(gnt), 64'(0));
      chk("wipe_no_rvalid", 64'(rvalid), 64'(0));
      if (n == 2) jtag = 1'b0;
      if (n == 3) jtag = 1'b1;
    end
    chk("wipe_len", 64'(n), 64'(NR));
    chk("wipe_gnt_resume", 64'(gnt), 64'(1));
    @(negedge clk);
    req = 1'b0; jtag = 1'b0;
    chk("wipe_held_rvalid", 64'(rvalid), 64'(1));
    chk("wipe_held_err",    64'(err),    64'(0));
    chk("wipe_held_rdata",  64'(rdata),  64'(0));
    chk("wipe_locked", 64'(locked), 64'(0));
    chk("wipe_busy_end", 64'(busy), 64'(0));
    for (int i = 0; i < NR; i++) chk("wipe_reg", 64'(ctrl[i*RW +: RW]), 64'(0));
    xact(0, 6, 0, 1, rd, e, g);  chk("wipe_wlock", 64'(rd), 64'(0));
    xact(0, 7, 0, 1, rd, e, g);  chk("wipe_rlock", 64'(rd), 64'(0));
    xact(1, 2, 32'h55, 1, rd, e, g); chk("wipe_open_wr_err", 64'(e), 64'(0));
    chk("wipe_open_reg2", 64'(ctrl[2*RW +: RW]), 64'(32'h55));

    // Violation counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) xact(1, 9, 0, 1, rd, e, g);
    chk("viol_saturate", 64'(viol), 64'(CNT_EN ? 255 : 0));

    // Write colliding with a wipe start, then reset in the middle of the wipe
    xact(1, 3, 32'h77, 1, rd, e, g);
    chk("pre_wipe_reg3", 64'(ctrl[3*RW +: RW]), 64'(32'h77));
    @(negedge clk);
    jtag = 1'b1; req = 1'b1; we = 1'b1; addr = AW'(1); wdata = 32'h99;
    #1 chk("collide_gnt", 64'(gnt), 64'(1));
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("collide_rvalid", 64'(rvalid), 64'(1));
    chk("collide_err",    64'(err),    64'(1));
    chk("collide_busy",   64'(busy),   64'(1));
    @(negedge clk);
    rst = 1'b1; jtag = 1'b0;
    @(negedge clk);
    chk("midwipe_busy",   64'(busy),   64'(0));
    chk("midwipe_locked", 64'(locked), 64'(0));
    chk("midwipe_viol",   64'(viol),   64'(0));
    chk("midwipe_rvalid", 64'(rvalid), 64'(0));
    chk("midwipe_reg3",   64'(ctrl[3*RW +: RW]), 64'(0));
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    chk("midwipe_stay_open", 64'(busy), 64'(0));

    // Randomized accesses against the model, with periodic wipes
    for (int it = 0; it < 400; it++) begin
      if (it % 100 == 99) begin
        @(negedge clk);
        jtag = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (!busy) break;
          n++;
        end
        jtag = 1'b0;
        chk("rnd_wipe_len", 64'(n), 64'(NR));
        m_wipe();
      end
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, NR + 2)) : int'($urandom_range(NR + 3, 15));
      if (a == NR + 2)      d = ($urandom_range(0, 3) == 0) ? 32'hA5 : $urandom;
      else if (a >= NR)     d = 32'(1) << $urandom_range(0, 7);
      else                  d = $urandom;
      me = ($urandom_range(0, 9) != 0);
      xact(w, a, d, me, rd, e, g);
      m_access(w, a, d, me, mrd, me);
      chk("rnd_gnt",    64'(g),      64'(1));
      chk("rnd_err",    64'(e),      64'(me));
      chk("rnd_rdata",  64'(rd),     64'(mrd));
      chk("rnd_locked", 64'(locked), 64'(m_locked));
      chk("rnd_viol",   64'(viol),   64'(exp_viol()));
    end
    for (int i = 0; i < NR; i++) chk("rnd_reg", 64'(ctrl[i*RW +: RW]), 64'(m_regs[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reglk_bank.md
REGLK_BANK -- requirements
Module: reglk_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 6: number of lockable data registers, 1..32.
REQ-002 SHALL have parameter REG_W, default 32: data register width, 8..64.
REQ-003 SHALL have parameter CNT_W, default 8: violation counter width.
REQ-004 SHALL have localparam AW = clog2(NUM_REGS+3): word address width.
REQ-005 SHALL have port clk_i, input, 1: the block's only clock.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port jtag_unlock_i, input, 1: debug unlock; a rising edge starts a wipe.
REQ-008 SHALL have port acct_ctrl_i, input, 1: access permission; low makes every access an error.
REQ-009 SHALL have ports req_i (input, 1), we_i (input, 1), addr_i (input, AW) and wdata_i (input, REG_W): request channel.
REQ-010 SHALL have port gnt_o, output, 1: request accepted this cycle.
REQ-011 SHALL have ports rvalid_o (output, 1), rdata_o (output, REG_W) and err_o (output, 1): response channel.
REQ-012 SHALL have port reglk_ctrl_o, output, NUM_REGS*REG_W: all data registers concatenated, register 0 in the LSBs.
REQ-013 SHALL have ports locked_o (output, 1: FSM is COMMITTED), busy_o (output, 1: FSM is WIPE) and viol_cnt_o (output, CNT_W).

Function
REQ-014 SHALL decode addresses as: 0..NUM_REGS-1 data; NUM_REGS WLOCK mask; NUM_REGS+1 RLOCK mask; NUM_REGS+2 COMMIT/status.
REQ-015 SHALL implement FSM states OPEN, COMMITTED and WIPE.
REQ-016 SHALL drive gnt_o = req_i whenever the FSM is not in WIPE, and gnt_o = 0 in WIPE so requests stall.
REQ-017 SHALL assert rvalid_o for exactly one cycle, in the cycle after each grant.
REQ-018 SHALL update rdata_o and err_o together with rvalid_o; when rvalid_o is low, both SHALL be 0.
REQ-019 SHALL make a data write take effect in the cycle after grant.
REQ-020 SHALL reject a data write to register i, leaving it unchanged and setting err_o, when WLOCK[i]=1, the FSM is COMMITTED, or acct_ctrl_i=0.
REQ-021 SHALL make WLOCK and RLOCK sticky-set: written bits are ORed in, bits are never cleared by writes, and bits at or above NUM_REGS are ignored.
REQ-022 SHALL reject WLOCK/RLOCK writes with err_o when the FSM is COMMITTED.
REQ-023 SHALL return rdata 0 with err_o=1 for a data read of register i when RLOCK[i]=1.
REQ-024 SHALL return WLOCK and RLOCK reads normally; they are never read-protected.
REQ-025 SHALL move OPEN -> COMMITTED on a write of 0xA5 to COMMIT (err_o=0); any other COMMIT write SHALL set err_o with no state change.
REQ-026 SHALL return {busy, locked} in bits [1:0] on a COMMIT read, zero-extended.
REQ-027 SHALL return rdata 0 with err_o=1 for an out-of-range address, with no state change.
REQ-028 SHALL, on a jtag_unlock_i rising edge in OPEN or COMMITTED, enter WIPE and clear one data register per cycle, index 0 up to NUM_REGS-1.
REQ-029 SHALL clear WLOCK and RLOCK in the final WIPE cycle and then return to OPEN; WIPE lasts exactly NUM_REGS cycles.
REQ-030 SHALL make a wipe-start edge win over a write granted in the same cycle: that write is discarded and its response reports err_o=1.
REQ-031 SHALL still deliver the response of a request granted before WIPE was entered.
REQ-032 SHALL ignore further jtag_unlock_i edges while in WIPE.
REQ-033 SHALL increment viol_cnt_o by 1 per err_o response, saturating at all-ones.

Reset
REQ-034 SHALL, with rst_i=1 at a clk_i edge, clear all data registers, WLOCK, RLOCK and viol_cnt_o, set the FSM to OPEN, and drive rvalid_o/err_o/rdata_o to 0.
REQ-035 SHALL abort an in-progress wipe or pending response immediately on reset, with no response issued.
REQ-036 SHALL give reset priority over all other events.

Configuration
REQ-037 SHALL compile the violation counter only when macro REGLK_VIOL_CNT_EN is defined.
REQ-038 SHALL tie viol_cnt_o to 0 and synthesise no counter when REGLK_VIOL_CNT_EN is undefined; all other behaviour is identical.

Structure
REQ-039 SHALL take the FSM state enum, the COMMIT magic 0xA5 and the WLOCK/RLOCK/COMMIT offsets (relative to NUM_REGS) from shared package reglk_pkg.
REQ-040 SHALL place the saturating counter in one sub-module, reglk_sat_counter (parameter CNT_W; ports inc_i, clr_i, cnt_o).

Verification
REQ-041 SHALL cover: write 0x1234_5678 to reg 2, read reg 2 -> rvalid one cycle after grant, rdata 0x1234_5678, err 0.
REQ-042 SHALL cover: WLOCK write 0x4, then write 0xFFFF_FFFF to reg 2 -> err 1, reg 2 unchanged, viol_cnt 1.
REQ-043 SHALL cover: RLOCK write 0x1, read reg 0 -> rdata 0, err 1; then RLOCK write 0x0 -> RLOCK still reads 0x1.
REQ-044 SHALL cover: COMMIT write 0x5A -> err 1, locked_o 0; COMMIT write 0xA5 -> locked_o 1; then any data write -> err 1.
REQ-045 SHALL cover: regs loaded and committed, pulse jtag_unlock_i -> busy_o high 6 cycles, requests stall (gnt_o 0), then all regs 0, WLOCK/RLOCK 0, OPEN.
REQ-046 SHALL cover: 300 violations with CNT_W=8 -> viol_cnt_o 255; rst_i mid-WIPE -> next cycle OPEN, busy_o 0, counter 0.
